// File: rtl/ro_meas_ctrl_if.sv
// rtl/ro_meas_ctrl_if.sv - request, oscillator and result signals of the ring-oscillator measurement controller
interface ro_meas_ctrl_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16,
  parameter int WIN_W    = 16,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic                START;
  logic [CH_W-1:0]     CH_SEL;
  logic [WIN_W-1:0]    WINDOW;
  logic [CHANNELS-1:0] RO_IN;
  logic [CHANNELS-1:0] EN_VCO;
  logic                BUSY;
  logic [CNT_W-1:0]    CNT;
  logic [CH_W-1:0]     CH_OUT;
  logic                OVF;
  logic                CNT_VALID;
  logic                CNT_READY;

  modport master (
    output START, CH_SEL, WINDOW, RO_IN, CNT_READY,
    input  EN_VCO, BUSY, CNT, CH_OUT, OVF, CNT_VALID
  );

  modport slave (
    input  START, CH_SEL, WINDOW, RO_IN, CNT_READY,
    output EN_VCO, BUSY, CNT, CH_OUT, OVF, CNT_VALID
  );
endinterface

// File: rtl/ro_meas_ctrl.sv
// rtl/ro_meas_ctrl.sv - enables one ring oscillator, lets it settle, counts its edges over a window
module ro_meas_ctrl #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 16,
  parameter int SETTLE_CYC  = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic         CLK,
  input logic         RSTN,
  ro_meas_ctrl_if.slave bus
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ST_W = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, COUNT, HOLD} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
  logic [CHANNELS-1:0] prev_q;
  logic [CH_W-1:0]     ch_q, ch_out_q;
  logic [WIN_W-1:0]    win_q, win_cnt_q;
  logic [ST_W-1:0]     settle_cnt_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                ovf_q, valid_q;
  logic                start_ok, settle_done, count_done, rise, vco_on;
  logic [CHANNELS-1:0] en_vco;

  assign start_ok    = bus.START && (int'(bus.CH_SEL) < CHANNELS);
  assign settle_done = (settle_cnt_q == ST_W'(SETTLE_CYC - 1));
  assign count_done  = (win_cnt_q == win_q - WIN_W'(1));
  assign rise        = sync_q[SYNC_STAGES-1][ch_q] & ~prev_q[ch_q];
  assign vco_on      = (state_q == SETTLE) || (state_q == COUNT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = SETTLE;
      SETTLE:  if (settle_done) state_d = (win_q != '0) ? COUNT : HOLD;
      COUNT:   if (count_done) state_d = HOLD;
      HOLD:    if (valid_q && bus.CNT_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    en_vco = '0;
    for (int i = 0; i < CHANNELS; i++) en_vco[i] = vco_on && (int'(ch_q) == i);
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q      <= IDLE;
      sync_q       <= '0;
      prev_q       <= '0;
      ch_q         <= '0;
      ch_out_q     <= '0;
      win_q        <= '0;
      win_cnt_q    <= '0;
      settle_cnt_q <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      // Synchronisers run in every state so the selected channel is clean by the end of SETTLE.
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.RO_IN};
      prev_q  <= sync_q[SYNC_STAGES-1];
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            ch_q         <= bus.CH_SEL;
            win_q        <= bus.WINDOW;
            settle_cnt_q <= '0;
          end
        end
        SETTLE: begin
          settle_cnt_q <= settle_cnt_q + ST_W'(1);
          if (settle_done) begin
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            win_cnt_q <= '0;
            if (win_q == '0) begin
              valid_q  <= 1'b1;
              ch_out_q <= ch_q;
            end
          end
        end
        COUNT: begin
          win_cnt_q <= win_cnt_q + WIN_W'(1);
          if (rise) begin
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q >= CNT_MAX - CNT_W'(1)) ovf_q <= 1'b1;
          end
          if (count_done) begin
            valid_q  <= 1'b1;
            ch_out_q <= ch_q;
          end
        end
        HOLD: begin
          if (bus.CNT_READY) valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.EN_VCO    = en_vco;
  assign bus.BUSY      = (state_q != IDLE);
  assign bus.CNT       = cnt_q;
  assign bus.CH_OUT    = ch_out_q;
  assign bus.OVF       = ovf_q;
  assign bus.CNT_VALID = valid_q;
endmodule

// File: tb/tb_ro_meas_ctrl.sv
// tb/tb_ro_meas_ctrl.sv - randomized scoreboard bench for ro_meas_ctrl
module tb_ro_meas_ctrl;
  localparam int CH   = 3;
  localparam int CW   = 8;
  localparam int WW   = 10;
  localparam int S    = 8;
  localparam int SS   = 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam int LIM  = 3000;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  ro_meas_ctrl_if #(.CHANNELS(CH), .CNT_W(CW), .WIN_W(WW)) bus ();

  ro_meas_ctrl #(
    .CHANNELS(CH), .CNT_W(CW), .WIN_W(WW), .SETTLE_CYC(S), .SYNC_STAGES(SS)
  ) dut (
    .CLK(clk),
    .RSTN(rstn),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {int ch; int lo; int hi; int ov; int lat; int en; int start;} exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ro_per = 10;
  int ro_sel = 0;
  int last_cnt = 0;
  int last_ch = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_rng(input string name, input logic [31:0] act, input int lo, input int hi);
    total++;
    if ($isunknown(act) || int'(act) < lo || int'(act) > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  // Oscillator model: selected channel is a square wave of period ro_per, others toggle every cycle.
  initial begin
    int ph;
    logic tog;
    ph = 0;
    tog = 1'b0;
    bus.RO_IN = '0;
    forever begin
      @(negedge clk);
      ph  = (ph + 1 >= ro_per) ? 0 : ph + 1;
      tog = ~tog;
      for (int i = 0; i < CH; i++) bus.RO_IN[i] = (i == ro_sel) ? (ph < ro_per / 2) : tog;
    end
  end

  // Monitor: compares each presented result against the scoreboard and checks HOLD stability.
  initial begin
    logic prev_valid, hs_prev;
    int en_cnt;
    logic [CW-1:0] h_cnt;
    logic [1:0] h_ch;
    logic h_ovf;
    prev_valid = 1'b0;
    hs_prev = 1'b0;
    en_cnt = 0;
    h_cnt = '0;
    h_ch = '0;
    h_ovf = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rstn) begin
        prev_valid = 1'b0;
        hs_prev = 1'b0;
        en_cnt = 0;
        continue;
      end
      if (hs_prev) begin
        check("busy_after_handshake", bus.BUSY, 0);
        check("valid_after_handshake", bus.CNT_VALID, 0);
      end
      hs_prev = 1'b0;
      check("en_vco_at_most_one", $countones(bus.EN_VCO) <= 1, 1);
      if (exp_q.size() > 0 && bus.EN_VCO == CH'(1 << exp_q[0].ch)) en_cnt++;
      if (!bus.BUSY) begin
        check("idle_cnt_kept", bus.CNT, last_cnt);
        check("idle_ch_kept", bus.CH_OUT, last_ch);
      end
      if (bus.CNT_VALID) begin
        if (!prev_valid) begin
          check("result_expected", exp_q.size() > 0, 1);
          h_cnt = bus.CNT;
          h_ch  = bus.CH_OUT;
          h_ovf = bus.OVF;
          if (exp_q.size() > 0) begin
            check("latency", cyc - exp_q[0].start, exp_q[0].lat);
            check_rng("cnt", bus.CNT, exp_q[0].lo, exp_q[0].hi);
            check("ch_out", bus.CH_OUT, exp_q[0].ch);
            check("ovf", bus.OVF, exp_q[0].ov);
            check("en_vco_cycles", en_cnt, exp_q[0].en);
          end
        end else begin
          check("hold_cnt_stable", bus.CNT, h_cnt);
          check("hold_ch_stable", bus.CH_OUT, h_ch);
          check("hold_ovf_stable", bus.OVF, h_ovf);
        end
        if (bus.CNT_READY) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          last_cnt = int'(h_cnt);
          last_ch  = int'(h_ch);
          hs_prev  = 1'b1;
          en_cnt   = 0;
        end
      end
      prev_valid = bus.CNT_VALID && !bus.CNT_READY;
    end
  end

  task automatic run_one(input int ch, input int p, input int w, input int lo, input int hi,
                         input int ov, input bit hold_mode, input bit abort);
    int n, hold_cnt;
    n = 0;
    while (bus.BUSY !== 1'b0 && n < LIM) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait_in_time", n < LIM, 1);
    ro_sel = ch;
    ro_per = p;
    bus.START  = 1'b1;
    bus.CH_SEL = 2'd3;
    bus.WINDOW = WW'(w);
    @(negedge clk);
    bus.START = 1'b0;
    check("bad_ch_busy", bus.BUSY, 0);
    check("bad_ch_en_vco", bus.EN_VCO, 0);
    bus.START  = 1'b1;
    bus.CH_SEL = 2'(ch);
    bus.WINDOW = WW'(w);
    if (!abort) exp_q.push_back('{ch, lo, hi, ov, S + w + 1, S + w, cyc});
    @(negedge clk);
    bus.START = 1'b0;
    if (abort) begin
      repeat (S + $urandom_range(1, w - 10)) @(negedge clk);
      rstn = 1'b0;
      last_cnt = 0;
      last_ch = 0;
      @(negedge clk);
      check("abort_en_vco", bus.EN_VCO, 0);
      check("abort_busy", bus.BUSY, 0);
      check("abort_valid", bus.CNT_VALID, 0);
      check("abort_cnt", bus.CNT, 0);
      check("abort_ovf", bus.OVF, 0);
      rstn = 1'b1;
      return;
    end
    hold_cnt = 0;
    n = 0;
    while (n < LIM && bus.BUSY !== 1'b0) begin
      bus.START  = ($urandom_range(0, 3) == 0);
      bus.CH_SEL = 2'($urandom_range(0, 3));
      bus.WINDOW = WW'($urandom);
      if (bus.CNT_VALID) hold_cnt++;
      bus.CNT_READY = hold_mode ? (hold_cnt > 20) : 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    bus.START = 1'b0;
    bus.CNT_READY = 1'b0;
    check("measure_done_in_time", n < LIM, 1);
  endtask

  initial begin
    int ch, p, w, lo, hi, ov;
    bit hold_mode, abort;
    bus.START = 1'b0;
    bus.CH_SEL = '0;
    bus.WINDOW = '0;
    bus.CNT_READY = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.BUSY, 0);
    check("rst_en_vco", bus.EN_VCO, 0);
    check("rst_valid", bus.CNT_VALID, 0);
    check("rst_cnt", bus.CNT, 0);
    check("rst_ch_out", bus.CH_OUT, 0);
    check("rst_ovf", bus.OVF, 0);
    rstn = 1'b1;
    for (int t = 0; t < 30; t++) begin
      hold_mode = 1'b0;
      abort = 1'b0;
      case (t)
        0: begin ch = 2; p = 10; w = 100; end
        1: begin ch = 1; p = 5;  w = 0;   end
        2: begin ch = 0; p = 2;  w = 600; end
        3: begin ch = 2; p = 4;  w = 200; abort = 1'b1; end
        4: begin ch = 1; p = 7;  w = 50;  hold_mode = 1'b1; end
        default: begin
          ch = $urandom_range(0, CH - 1);
          p = $urandom_range(2, 12);
          hold_mode = ($urandom_range(0, 3) == 0);
          do begin
            w = $urandom_range(0, 700);
            lo = w / p;
            hi = lo + ((w % p) != 0 ? 1 : 0);
          end while (!(hi < CMAX || lo >= CMAX));
          abort = ($urandom_range(0, 9) == 0) && (w > 20);
        end
      endcase
      lo = w / p;
      hi = lo + ((w % p) != 0 ? 1 : 0);
      ov = (lo >= CMAX) ? 1 : 0;
      if (ov != 0) begin
        lo = CMAX;
        hi = CMAX;
      end
      run_one(ch, p, w, lo, hi, ov, hold_mode, abort);
    end
    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
